// File: rtl/wb_arb2.sv
`default_nettype none
//==============================================================================
// Module   : wb_arb2
// Brief    : Two-master, one-slave Wishbone arbiter sharing a wb2byteio port.
//            Round-robin priority. A grant is held from bus-cycle start until
//            the slave ack or a master abort. One idle cycle between transfers.
// Options  : WB_ARB_TIMEOUT_EN - adds a hung-slave timeout that forces the
//            grant off after TMO_CYC cycles without ack and pulses o_mX_err.
// Revision : 1.0 - initial release
//==============================================================================
module wb_arb2 #(
   parameter int ASIZE   = 2,
   parameter int DSIZE   = 8,
   parameter int TMO_CYC = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   // master 0
   input  logic [ASIZE-1:0] i_m0_adr,
   input  logic             i_m0_stb,
   input  logic             i_m0_we,
   input  logic [DSIZE-1:0] i_m0_dat,
   output logic             o_m0_ack,
   output logic [DSIZE-1:0] o_m0_dat,
   output logic             o_m0_err,
   // master 1
   input  logic [ASIZE-1:0] i_m1_adr,
   input  logic             i_m1_stb,
   input  logic             i_m1_we,
   input  logic [DSIZE-1:0] i_m1_dat,
   output logic             o_m1_ack,
   output logic [DSIZE-1:0] o_m1_dat,
   output logic             o_m1_err,
   // slave
   output logic [ASIZE-1:0] o_s_adr,
   output logic             o_s_stb,
   output logic             o_s_we,
   output logic [DSIZE-1:0] o_s_dat,
   input  logic             i_s_ack,
   input  logic [DSIZE-1:0] i_s_dat,
   // grant {m1,m0}
   output logic [1:0]       o_gnt
);

   // State codes double as the one-hot grant, so o_gnt comes straight off flops.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_GNT0 = 2'b01,
      ST_GNT1 = 2'b10
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   r_last_gnt;      // master that held the most recent grant
   logic   w_last_gnt_nxt;
   logic   w_tmo;           // current grant has run out of time this cycle

   assign o_gnt = r_state;

   // TMO_CYC below 3 leaves no cycle between grant and forced release.
   if (TMO_CYC < 3) begin : g_tmo_cyc_too_small
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int                 c_tmo_w    = $clog2(TMO_CYC + 1);
   localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TMO_CYC - 1);

   logic [c_tmo_w-1:0] r_tmo_cnt;

   // Age of the current grant in ack-less cycles; restarts whenever the bus is idle.
   always_ff @(posedge i_clk) begin
      if (i_rst || r_state == ST_IDLE) begin
         r_tmo_cnt <= '0;
      end else if (!i_s_ack) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   // An ack arriving on the last allowed cycle still completes the transfer.
   assign w_tmo = (r_state != ST_IDLE) && !i_s_ack && (r_tmo_cnt == c_tmo_last);
`else
   assign w_tmo = 1'b0;
`endif

   // State and round-robin history registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_last_gnt <= 1'b1;        // m0 wins the first contested arbitration
      end else begin
         r_state    <= w_state_nxt;
         r_last_gnt <= w_last_gnt_nxt;
      end
   end

   // Arbitration in IDLE; release on ack, abort or timeout while granted.
   always_comb begin
      w_state_nxt    = r_state;
      w_last_gnt_nxt = r_last_gnt;
      case (r_state)
         ST_IDLE: begin
            if (i_m0_stb && i_m1_stb) begin
               w_state_nxt = r_last_gnt ? ST_GNT0 : ST_GNT1;
            end else if (i_m0_stb) begin
               w_state_nxt = ST_GNT0;
            end else if (i_m1_stb) begin
               w_state_nxt = ST_GNT1;
            end
         end
         ST_GNT0: begin
            if (i_s_ack || !i_m0_stb || w_tmo) begin
               w_state_nxt    = ST_IDLE;
               w_last_gnt_nxt = 1'b0;
            end
         end
         ST_GNT1: begin
            if (i_s_ack || !i_m1_stb || w_tmo) begin
               w_state_nxt    = ST_IDLE;
               w_last_gnt_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Route the granted master to the slave and the slave response back to it.
   always_comb begin
      o_s_adr  = '0;
      o_s_stb  = 1'b0;
      o_s_we   = 1'b0;
      o_s_dat  = '0;
      o_m0_ack = 1'b0;
      o_m0_dat = '0;
      o_m0_err = 1'b0;
      o_m1_ack = 1'b0;
      o_m1_dat = '0;
      o_m1_err = 1'b0;
      case (r_state)
         ST_GNT0: begin
            o_s_adr  = i_m0_adr;
            o_s_stb  = i_m0_stb & ~w_tmo;
            o_s_we   = i_m0_we;
            o_s_dat  = i_m0_dat;
            o_m0_ack = i_s_ack;
            o_m0_dat = i_s_dat;
            o_m0_err = w_tmo;
         end
         ST_GNT1: begin
            o_s_adr  = i_m1_adr;
            o_s_stb  = i_m1_stb & ~w_tmo;
            o_s_we   = i_m1_we;
            o_s_dat  = i_m1_dat;
            o_m1_ack = i_s_ack;
            o_m1_dat = i_s_dat;
            o_m1_err = w_tmo;
         end
         default: begin
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_arb2.sv
`default_nettype none
//==============================================================================
// Module   : tb_wb_arb2
// Brief    : Self-checking bench for wb_arb2: directed scenarios with literal
//            expectations, then randomized traffic against a behavioural model.
//            Build with WB_ARB_TIMEOUT_EN defined to cover the timeout option.
// Revision : 1.0 - initial release
//==============================================================================
module tb_wb_arb2;
   localparam int ASIZE   = 2;
   localparam int DSIZE   = 8;
   localparam int TMO_CYC = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]       m_stb = 2'b00;
   logic [1:0]       m_we  = 2'b00;
   logic [ASIZE-1:0] m_adr [2] = '{default: '0};
   logic [DSIZE-1:0] m_dat [2] = '{default: '0};

   logic             m0_ack, m1_ack, m0_err, m1_err;
   logic [DSIZE-1:0] m0_rdat, m1_rdat;
   logic [ASIZE-1:0] s_adr;
   logic             s_stb, s_we;
   logic [DSIZE-1:0] s_wdat, s_rdat;
   logic             s_ack = 1'b0;
   logic [1:0]       gnt;

   wb_arb2 #(.ASIZE(ASIZE), .DSIZE(DSIZE), .TMO_CYC(TMO_CYC)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_m0_adr(m_adr[0]), .i_m0_stb(m_stb[0]), .i_m0_we(m_we[0]), .i_m0_dat(m_dat[0]),
      .o_m0_ack(m0_ack), .o_m0_dat(m0_rdat), .o_m0_err(m0_err),
      .i_m1_adr(m_adr[1]), .i_m1_stb(m_stb[1]), .i_m1_we(m_we[1]), .i_m1_dat(m_dat[1]),
      .o_m1_ack(m1_ack), .o_m1_dat(m1_rdat), .o_m1_err(m1_err),
      .o_s_adr(s_adr), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_dat(s_wdat),
      .i_s_ack(s_ack), .i_s_dat(s_rdat),
      .o_gnt(gnt)
   );

   // ---------------- slave: byte register file with registered ack ----------
   logic [DSIZE-1:0] mem [4] = '{default: '0};
   bit               hang      = 1'b0;
   bit               rand_mode = 1'b0;

   assign s_rdat = mem[s_adr];

   // Ack one cycle after stb (random extra wait in random mode); stray acks while idle.
   always @(posedge clk) begin
      if (s_stb && s_we && s_ack) mem[s_adr] <= s_wdat;
      if (hang)
         s_ack <= 1'b0;
      else if (s_stb && !s_ack)
         s_ack <= rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      else
         s_ack <= rand_mode && !s_stb && ($urandom_range(0, 15) == 0);
   end

   // ---------------- checking ----------------
   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Model state: owner of the bus (-1 idle), previous owner, cycles into grant.
   bit mdl_ok = 1'b0;
   int own    = -1;
   int lst    = 1;
   int age    = 0;
   bit auto_drop = 1'b1;

   logic [1:0]       smp_gnt, smp_ack, smp_err;
   logic             smp_sstb;
   logic [DSIZE-1:0] smp_sdat, smp_dat1;

   // One clock: sample and check at negedge, advance the model, then drive after posedge.
   task automatic step();
      logic       tmo;
      logic [1:0] e_ack, e_err;
      @(negedge clk);
      smp_gnt  = gnt;
      smp_ack  = {m1_ack, m0_ack};
      smp_err  = {m1_err, m0_err};
      smp_sstb = s_stb;
      smp_sdat = s_wdat;
      smp_dat1 = m1_rdat;
      if (mdl_ok) begin
         tmo   = 1'b0;
         e_ack = 2'b00;
         e_err = 2'b00;
         if (own >= 0) begin
`ifdef WB_ARB_TIMEOUT_EN
            tmo = (age == TMO_CYC) && !s_ack;
`endif
            e_ack[own] = s_ack;
            e_err[own] = tmo;
            chk("gnt",   gnt,    32'(1 << own));
            chk("s_stb", s_stb,  m_stb[own] && !tmo);
            chk("s_adr", s_adr,  m_adr[own]);
            chk("s_we",  s_we,   m_we[own]);
            chk("s_dat", s_wdat, m_dat[own]);
         end else begin
            chk("gnt",   gnt,    0);
            chk("s_stb", s_stb,  0);
            chk("s_adr", s_adr,  0);
            chk("s_we",  s_we,   0);
            chk("s_dat", s_wdat, 0);
         end
         chk("ack",    smp_ack, e_ack);
         chk("err",    smp_err, e_err);
         chk("m0_dat", m0_rdat, (own == 0) ? s_rdat : 0);
         chk("m1_dat", m1_rdat, (own == 1) ? s_rdat : 0);
         // advance the model across the coming edge
         if (!rst) begin
            if (own < 0) begin
               if (m_stb == 2'b11)  own = 1 - lst;
               else if (m_stb[0])   own = 0;
               else if (m_stb[1])   own = 1;
               age = 1;
            end else if (s_ack || !m_stb[own] || tmo) begin
               lst = own;
               own = -1;
            end else begin
               age++;
            end
         end
      end
      if (rst) begin
         mdl_ok = 1'b1;
         own    = -1;
         lst    = 1;
         age    = 0;
      end
      @(posedge clk);
      #1;
      for (int x = 0; x < 2; x++)
         if (auto_drop && m_stb[x] && (smp_ack[x] || smp_err[x])) m_stb[x] = 1'b0;
      if (rand_mode) begin
         rst = ($urandom_range(0, 299) == 0);
         for (int x = 0; x < 2; x++) begin
            if (m_stb[x]) begin
               if ($urandom_range(0, 29) == 0) m_stb[x] = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
               m_stb[x] = 1'b1;
               m_we[x]  = 1'($urandom);
               m_adr[x] = ASIZE'($urandom);
               m_dat[x] = DSIZE'($urandom);
            end
         end
      end
   endtask

   logic [1:0]       tg[$], ta[$];
   logic [DSIZE-1:0] tsd[$], td1[$];

   task automatic run_trace(input int n);
      tg.delete(); ta.delete(); tsd.delete(); td1.delete();
      for (int k = 0; k < n; k++) begin
         step();
         tg.push_back(smp_gnt);
         ta.push_back(smp_ack);
         tsd.push_back(smp_sdat);
         td1.push_back(smp_dat1);
      end
   endtask

   task automatic cmp_trace(input string tag, input logic [1:0] eg[$], input logic [1:0] ea[$]);
      for (int k = 0; k < eg.size(); k++) begin
         chk($sformatf("%s_gnt%0d", tag, k), tg[k], eg[k]);
         chk($sformatf("%s_ack%0d", tag, k), ta[k], ea[k]);
      end
   endtask

   task automatic set_m(input int x, input logic we, input logic [ASIZE-1:0] adr,
                        input logic [DSIZE-1:0] dat);
      m_stb[x] = 1'b1;
      m_we[x]  = we;
      m_adr[x] = adr;
      m_dat[x] = dat;
   endtask

   initial begin
      int order[4];
      int n_ack;
      int err_step;
      logic [1:0] g18;

      // 1: reset held two cycles
      rst = 1'b1;
      step();
      step();
      chk("t1_gnt",  smp_gnt,  0);
      chk("t1_sstb", smp_sstb, 0);
      chk("t1_ack",  smp_ack,  0);
      chk("t1_err",  smp_err,  0);
      chk("t1_dat1", smp_dat1, 0);
      rst = 1'b0;

      // 2: single m0 write of A5 to address 1
      set_m(0, 1'b1, 2'b01, 8'hA5);
      run_trace(4);
      cmp_trace("t2", '{2'd0, 2'd1, 2'd1, 2'd0}, '{2'd0, 2'd0, 2'd1, 2'd0});
      chk("t2_sdat", tsd[1], 8'hA5);
      chk("t2_mem1", mem[1], 8'hA5);

      // 3: simultaneous requests after reset: m0 first, idle cycle, then m1 reads A5
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_m(0, 1'b1, 2'b10, 8'h00);
      set_m(1, 1'b0, 2'b01, 8'h00);
      run_trace(7);
      cmp_trace("t3", '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0},
                      '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0});
      chk("t3_m1_rdat", td1[5], 8'hA5);

      // 4: both requests held: grants must alternate m0,m1,m0,m1
      auto_drop = 1'b0;
      set_m(0, 1'b1, 2'b11, 8'h3C);
      set_m(1, 1'b0, 2'b11, 8'h00);
      n_ack = 0;
      for (int k = 0; k < 60 && n_ack < 4; k++) begin
         step();
         if (smp_ack != 2'b00) begin
            order[n_ack] = smp_ack[1] ? 1 : 0;
            n_ack++;
         end
      end
      chk("t4_acks", n_ack, 4);
      for (int k = 0; k < n_ack; k++) chk($sformatf("t4_order%0d", k), order[k], k % 2);
      m_stb = 2'b00;
      auto_drop = 1'b1;
      step();

      // 5: m1 aborts before ack; m0 is granted afterwards
      hang = 1'b1;
      set_m(1, 1'b0, 2'b00, 8'h00);
      run_trace(2);
      m_stb[1] = 1'b0;
      hang = 1'b0;
      set_m(0, 1'b0, 2'b01, 8'h00);
      begin
         logic [1:0] g01[$], a01[$];
         g01 = tg; a01 = ta;
         run_trace(5);
         tg = {g01, tg};
         ta = {a01, ta};
      end
      cmp_trace("t5", '{2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0},
                      '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0});

      // 6: hung slave with m0 holding its request
      hang = 1'b1;
      set_m(0, 1'b0, 2'b10, 8'h00);
      err_step = 0;
      g18 = 2'b11;
      for (int k = 1; k <= 18; k++) begin
         step();
         if (smp_err[0] && err_step == 0) err_step = k;
         if (k == 18) g18 = smp_gnt;
      end
`ifdef WB_ARB_TIMEOUT_EN
      chk("t6_err_step", err_step, 17);
      chk("t6_gnt_after", g18, 0);
`else
      chk("t6_err_step", err_step, 0);
      chk("t6_gnt_held", g18, 1);
`endif
      m_stb = 2'b00;
      hang  = 1'b0;
      step();
      step();

      // random traffic with stray acks, aborts, resets and hung-slave windows
      rand_mode = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         hang = (i % 400) >= 360;
         step();
      end
      rand_mode = 1'b0;
      rst   = 1'b0;
      m_stb = 2'b00;
      hang  = 1'b0;
      step();
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
